// File: rtl/gene_stream_loader.sv
// gene_stream_loader: loads reference B into a parallel register, buffers query A,
// then replays A gap-free one base per cycle with start/stop framing.
module gene_stream_loader #(
  parameter int B_LEN = 64,
  parameter int A_MAX = 256,
  parameter int LEN_W = 16
) (
  input  logic               i_clk,
  input  logic               i_rst_n,
  input  logic               i_cfg_valid,
  input  logic [LEN_W-1:0]   i_a_len,
  input  logic               i_abort,
  input  logic               i_in_valid,
  output logic               o_in_ready,
  input  logic [1:0]         i_in_base,
  output logic [2*B_LEN-1:0] o_B,
  output logic [1:0]         o_A,
  output logic               o_start,
  output logic               o_stop,
  output logic               o_busy,
  output logic               o_done,
  output logic               o_err
);
  localparam int CW = $clog2(B_LEN > A_MAX ? B_LEN : A_MAX) + 1;
  localparam int AW = $clog2(A_MAX);
  localparam logic [2:0] IDLE   = 3'd0;
  localparam logic [2:0] LOAD_B = 3'd1;
  localparam logic [2:0] LOAD_A = 3'd2;
  localparam logic [2:0] STREAM = 3'd3;
  localparam logic [2:0] DONE   = 3'd4;
  logic [2:0]    r_state;
  logic [CW-1:0] r_cnt;
  logic [CW-1:0] r_len;
  logic [1:0]    r_mem [A_MAX];
  logic          w_hs;
  logic          w_cfg_ok;
  logic [AW-1:0] w_idx;
  assign w_hs     = i_in_valid & o_in_ready;
  assign w_cfg_ok = (i_a_len != '0) && (i_a_len <= LEN_W'(A_MAX));
  assign w_idx    = r_cnt[AW-1:0];
  // Query buffer has no reset; it is only read after being written in LOAD_A.
  always_ff @(posedge i_clk)
    if (r_state == LOAD_A && w_hs && !i_abort) r_mem[w_idx] <= i_in_base;
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state    <= IDLE;
      r_cnt      <= '0;
      r_len      <= '0;
      o_B        <= '0;
      o_A        <= '0;
      o_start    <= 1'b0;
      o_stop     <= 1'b0;
      o_in_ready <= 1'b0;
      o_busy     <= 1'b0;
      o_done     <= 1'b0;
      o_err      <= 1'b0;
    end else begin
      o_err   <= 1'b0;
      o_done  <= 1'b0;
      o_start <= 1'b0;
      o_stop  <= 1'b0;
      o_A     <= '0;
      if (i_abort && r_state != IDLE) begin
        r_state    <= IDLE;
        r_cnt      <= '0;
        o_in_ready <= 1'b0;
        o_busy     <= 1'b0;
      end else begin
        case (r_state)
          IDLE: if (i_cfg_valid && !i_abort) begin
            if (w_cfg_ok) begin
              r_len      <= CW'(i_a_len);
              r_cnt      <= '0;
              r_state    <= LOAD_B;
              o_in_ready <= 1'b1;
              o_busy     <= 1'b1;
            end else o_err <= 1'b1;
          end
          LOAD_B: if (w_hs) begin
            o_B[{r_cnt, 1'b0} +: 2] <= i_in_base;
            r_cnt   <= (r_cnt == CW'(B_LEN - 1)) ? '0 : r_cnt + 1'b1;
            r_state <= (r_cnt == CW'(B_LEN - 1)) ? LOAD_A : LOAD_B;
          end
          LOAD_A: if (w_hs) begin
            r_cnt      <= (r_cnt == r_len - 1'b1) ? '0 : r_cnt + 1'b1;
            r_state    <= (r_cnt == r_len - 1'b1) ? STREAM : LOAD_A;
            o_in_ready <= (r_cnt != r_len - 1'b1);
          end
          STREAM: if (r_cnt == r_len) begin
            r_state <= DONE;
            o_done  <= 1'b1;
          end else begin
            o_A     <= r_mem[w_idx];
            o_start <= (r_cnt == '0);
            o_stop  <= (r_cnt == r_len - 1'b1);
            r_cnt   <= r_cnt + 1'b1;
          end
          DONE: begin
            r_state <= IDLE;
            r_cnt   <= '0;
            o_busy  <= 1'b0;
          end
          default: r_state <= IDLE;
        endcase
      end
    end
  end
endmodule

// File: tb/tb_gene_stream_loader.sv
// tb_gene_stream_loader: randomized job-level checks of the B/A loader against a base-array model.
module tb_gene_stream_loader;
  localparam int B_LEN = 64;
  localparam int A_MAX = 256;
  localparam int LEN_W = 16;
  logic               i_clk = 1'b0;
  logic               i_rst_n = 1'b0;
  logic               i_cfg_valid = 1'b0;
  logic [LEN_W-1:0]   i_a_len = '0;
  logic               i_abort = 1'b0;
  logic               i_in_valid = 1'b0;
  logic               o_in_ready;
  logic [1:0]         i_in_base = '0;
  logic [2*B_LEN-1:0] o_B;
  logic [1:0]         o_A;
  logic               o_start, o_stop, o_busy, o_done, o_err;
  int n_cmp = 0;
  int n_bad = 0;
  int b_mod [B_LEN];
  int b_src [B_LEN];
  int a_mod [A_MAX];

  gene_stream_loader #(.B_LEN(B_LEN), .A_MAX(A_MAX), .LEN_W(LEN_W)) dut (
    .i_clk(i_clk), .i_rst_n(i_rst_n), .i_cfg_valid(i_cfg_valid), .i_a_len(i_a_len),
    .i_abort(i_abort), .i_in_valid(i_in_valid), .o_in_ready(o_in_ready), .i_in_base(i_in_base),
    .o_B(o_B), .o_A(o_A), .o_start(o_start), .o_stop(o_stop), .o_busy(o_busy),
    .o_done(o_done), .o_err(o_err)
  );

  always #5 i_clk = ~i_clk;

  task automatic tick();
    @(posedge i_clk);
    #1;
  endtask

  function automatic logic [2*B_LEN-1:0] exp_b();
    logic [2*B_LEN-1:0] v = '0;
    for (int k = 0; k < B_LEN; k++) v[2*k +: 2] = 2'(b_mod[k]);
    return v;
  endfunction

  task automatic randomize_job(input int len);
    for (int k = 0; k < B_LEN; k++) b_src[k] = int'($urandom_range(3));
    for (int k = 0; k < len; k++) a_mod[k] = int'($urandom_range(3));
  endtask

  // One complete job: cfg, B load, A load, stream, done; optional abort or reset injection.
  task automatic run_job(input int len, input int stall, input int abort_idx, input int rst_k, input string tag);
    int idx = 0;
    int cyc = 0;
    logic hs;
    i_cfg_valid = 1'b1;
    i_a_len = LEN_W'(len);
    tick();
    i_cfg_valid = 1'b0;
    n_cmp++;
    if (o_busy !== 1'b1 || o_in_ready !== 1'b1) begin
      n_bad++;
      $display("FAIL %s cfg_accept: busy=%b ready=%b required 1/1", tag, o_busy, o_in_ready);
    end
    while (idx < B_LEN + len && cyc < 20000) begin
      i_in_valid = ($urandom_range(99) >= stall);
      i_in_base = 2'(idx < B_LEN ? b_src[idx] : a_mod[idx - B_LEN]);
      if (idx == abort_idx) begin
        i_abort = 1'b1;
        i_in_valid = 1'b1;
      end
      n_cmp++;
      if (o_in_ready !== 1'b1) begin
        n_bad++;
        $display("FAIL %s load_ready idx=%0d: ready=%b required 1", tag, idx, o_in_ready);
      end
      hs = i_in_valid;
      tick();
      cyc++;
      if (i_abort) begin
        i_abort = 1'b0;
        i_in_valid = 1'b0;
        n_cmp++;
        if (o_busy !== 1'b0 || o_in_ready !== 1'b0 || o_B !== exp_b()) begin
          n_bad++;
          $display("FAIL %s abort: busy=%b ready=%b oB=%h required 0/0 oB=%h", tag, o_busy, o_in_ready, o_B, exp_b());
        end
        for (int j = 0; j < 3; j++) begin
          tick();
          n_cmp++;
          if (o_done !== 1'b0 || o_start !== 1'b0 || o_A !== 2'd0) begin
            n_bad++;
            $display("FAIL %s post_abort: done=%b start=%b A=%0d required 0/0/0", tag, o_done, o_start, o_A);
          end
        end
        return;
      end
      if (hs) begin
        if (idx < B_LEN) b_mod[idx] = b_src[idx];
        idx++;
      end
    end
    i_in_valid = 1'b0;
    n_cmp++;
    if (idx != B_LEN + len || o_in_ready !== 1'b0 || o_busy !== 1'b1 || o_A !== 2'd0) begin
      n_bad++;
      $display("FAIL %s load_end: idx=%0d ready=%b busy=%b A=%0d required %0d/0/1/0", tag, idx, o_in_ready, o_busy, o_A, B_LEN + len);
    end
    for (int k = 0; k < len; k++) begin
      i_in_valid = 1'($urandom_range(1));
      tick();
      n_cmp++;
      if (o_A !== 2'(a_mod[k]) || o_start !== (k == 0) || o_stop !== (k == len - 1) || o_B !== exp_b()) begin
        n_bad++;
        $display("FAIL %s stream k=%0d: A=%0d start=%b stop=%b oB=%h required A=%0d start=%b stop=%b oB=%h",
                 tag, k, o_A, o_start, o_stop, o_B, a_mod[k], k == 0, k == len - 1, exp_b());
      end
      if (k == rst_k) begin
        i_rst_n = 1'b0;
        i_in_valid = 1'b0;
        #1;
        for (int j = 0; j < B_LEN; j++) b_mod[j] = 0;
        n_cmp++;
        if ({o_A, o_start, o_stop, o_busy, o_done, o_err, o_in_ready} !== '0 || o_B !== '0) begin
          n_bad++;
          $display("FAIL %s async_reset: A=%0d start=%b stop=%b busy=%b done=%b err=%b ready=%b oB=%h required all 0",
                   tag, o_A, o_start, o_stop, o_busy, o_done, o_err, o_in_ready, o_B);
        end
        tick();
        tick();
        i_rst_n = 1'b1;
        tick();
        n_cmp++;
        if (o_done !== 1'b0 || o_busy !== 1'b0) begin
          n_bad++;
          $display("FAIL %s after_reset: done=%b busy=%b required 0/0", tag, o_done, o_busy);
        end
        return;
      end
    end
    i_in_valid = 1'b0;
    tick();
    n_cmp++;
    if (o_done !== 1'b1 || o_busy !== 1'b1 || o_A !== 2'd0 || o_start !== 1'b0 || o_stop !== 1'b0) begin
      n_bad++;
      $display("FAIL %s done_pulse: done=%b busy=%b A=%0d start=%b stop=%b required 1/1/0/0/0", tag, o_done, o_busy, o_A, o_start, o_stop);
    end
    tick();
    n_cmp++;
    if (o_done !== 1'b0 || o_busy !== 1'b0 || o_in_ready !== 1'b0) begin
      n_bad++;
      $display("FAIL %s idle_return: done=%b busy=%b ready=%b required 0/0/0", tag, o_done, o_busy, o_in_ready);
    end
  endtask

  task automatic test_reset();
    i_rst_n = 1'b0;
    #1;
    for (int j = 0; j < B_LEN; j++) b_mod[j] = 0;
    tick();
    i_rst_n = 1'b1;
    tick();
    n_cmp++;
    if ({o_A, o_start, o_stop, o_busy, o_done, o_err, o_in_ready} !== '0 || o_B !== '0) begin
      n_bad++;
      $display("FAIL reset_state: A=%0d start=%b stop=%b busy=%b done=%b err=%b ready=%b oB=%h required all 0",
               o_A, o_start, o_stop, o_busy, o_done, o_err, o_in_ready, o_B);
    end
  endtask

  task automatic test_nominal();
    logic [2*B_LEN-1:0] pat = {16{8'hE4}};
    for (int k = 0; k < B_LEN; k++) b_src[k] = k % 4;
    for (int k = 0; k < 63; k++) a_mod[k] = (k * 3) % 4;
    run_job(63, 0, -1, -1, "nominal");
    n_cmp++;
    if (o_B !== pat) begin
      n_bad++;
      $display("FAIL nominal_B: oB=%h required %h", o_B, pat);
    end
  endtask

  task automatic test_min_len();
    randomize_job(1);
    run_job(1, 0, -1, -1, "min_len");
  endtask

  task automatic test_max_len();
    randomize_job(A_MAX);
    run_job(A_MAX, 10, -1, -1, "max_len");
  endtask

  task automatic test_stalls();
    for (int r = 0; r < 3; r++) begin
      int len = int'($urandom_range(48, 1));
      randomize_job(len);
      run_job(len, 50, -1, -1, "stalls");
    end
  endtask

  task automatic test_invalid_cfg();
    int bad_len [3] = '{0, A_MAX + 1, 65535};
    foreach (bad_len[i]) begin
      i_cfg_valid = 1'b1;
      i_a_len = LEN_W'(bad_len[i]);
      tick();
      i_cfg_valid = 1'b0;
      n_cmp++;
      if (o_err !== 1'b1 || o_busy !== 1'b0 || o_in_ready !== 1'b0) begin
        n_bad++;
        $display("FAIL invalid_cfg len=%0d: err=%b busy=%b ready=%b required 1/0/0", bad_len[i], o_err, o_busy, o_in_ready);
      end
      tick();
      n_cmp++;
      if (o_err !== 1'b0 || o_busy !== 1'b0) begin
        n_bad++;
        $display("FAIL invalid_cfg_pulse len=%0d: err=%b busy=%b required 0/0", bad_len[i], o_err, o_busy);
      end
    end
    i_cfg_valid = 1'b1;
    i_abort = 1'b1;
    i_a_len = 16'd5;
    tick();
    i_cfg_valid = 1'b0;
    i_abort = 1'b0;
    n_cmp++;
    if (o_busy !== 1'b0 || o_err !== 1'b0 || o_in_ready !== 1'b0) begin
      n_bad++;
      $display("FAIL idle_abort_priority: busy=%b err=%b ready=%b required 0/0/0", o_busy, o_err, o_in_ready);
    end
  endtask

  task automatic test_abort();
    randomize_job(30);
    run_job(30, 20, 20, -1, "abort_in_B");
    randomize_job(30);
    run_job(30, 0, B_LEN + 10, -1, "abort_in_A");
    randomize_job(4);
    run_job(4, 0, -1, -1, "after_abort");
  endtask

  task automatic test_reset_mid_stream();
    randomize_job(12);
    run_job(12, 0, -1, 5, "rst_stream");
    randomize_job(20);
    run_job(20, 25, -1, -1, "after_rst");
  endtask

  task automatic test_back_to_back();
    for (int r = 0; r < 3; r++) begin
      int len = int'($urandom_range(16, 1));
      randomize_job(len);
      run_job(len, 0, -1, -1, "back_to_back");
    end
  endtask

  initial begin
    test_reset();
    test_nominal();
    test_min_len();
    test_max_len();
    test_stalls();
    test_invalid_cfg();
    test_abort();
    test_reset_mid_stream();
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
